// File: rtl/triple_pulse_stretcher.sv
// Three-channel pulse stretcher: turns single-cycle event pulses into
// mutually exclusive level outputs held for HOLD heartbeat ticks.
//
//   state | meaning
//   IDLE  | no channel active, all levels low
//   CH0   | channel 0 holding, L0 high
//   CH1   | channel 1 holding, L1 high
//   CH2   | channel 2 holding, L2 high
module triple_pulse_stretcher #(
  parameter int HB_WIDTH = 21,
  parameter int HOLD     = 3
) (
  input  logic sysclk,
  input  logic reset,
  input  logic P0,
  input  logic P1,
  input  logic P2,
  output logic L0,
  output logic L1,
  output logic L2,
  output logic busy,
  output logic collide
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CH0  = 2'd1,
    CH1  = 2'd2,
    CH2  = 2'd3
  } act_t;

  localparam logic [3:0]          HOLD_CNT = HOLD[3:0];
  localparam logic [HB_WIDTH-1:0] PRE_ONE  = {{(HB_WIDTH-1){1'b0}}, 1'b1};

  logic [HB_WIDTH-1:0] pre;
  logic                tick;
  act_t                act, act_next;
  logic [3:0]          cnt, cnt_next;
  logic [1:0]          pulse_sum;
  logic                accept;
  logic                collide_next;
  logic [2:0]          lvl_next;

  assign tick         = &pre;
  assign pulse_sum    = {1'b0, P0} + {1'b0, P1} + {1'b0, P2};
  assign accept       = (pulse_sum == 2'd1);
  assign collide_next = (pulse_sum >= 2'd2);
  assign busy         = L0 | L1 | L2;

  // Free-running heartbeat prescaler; only reset clears it, never a pulse.
  always_ff @(posedge sysclk) begin
    if (reset) pre <= '0;
    else       pre <= pre + PRE_ONE;
  end

  // Next channel/hold count: an accepted pulse always wins over a tick.
  always_comb begin
    act_next = act;
    cnt_next = cnt;
    if (accept) begin
      cnt_next = HOLD_CNT;
      if (P0)      act_next = CH0;
      else if (P1) act_next = CH1;
      else         act_next = CH2;
    end else if (tick && (cnt != 4'd0)) begin
      cnt_next = cnt - 4'd1;
      if (cnt == 4'd1) act_next = IDLE;
    end
  end

  // Levels are decoded from the next state so they rise one cycle after the pulse.
  always_comb begin
    lvl_next    = 3'b000;
    lvl_next[0] = (act_next == CH0) && (cnt_next != 4'd0);
    lvl_next[1] = (act_next == CH1) && (cnt_next != 4'd0);
    lvl_next[2] = (act_next == CH2) && (cnt_next != 4'd0);
  end

  // Channel, counter and registered outputs; reset dominates everything.
  always_ff @(posedge sysclk) begin
    if (reset) begin
      act     <= IDLE;
      cnt     <= 4'd0;
      L0      <= 1'b0;
      L1      <= 1'b0;
      L2      <= 1'b0;
      collide <= 1'b0;
    end else begin
      act     <= act_next;
      cnt     <= cnt_next;
      L0      <= lvl_next[0];
      L1      <= lvl_next[1];
      L2      <= lvl_next[2];
      collide <= collide_next;
    end
  end

endmodule

// File: tb/tb_triple_pulse_stretcher.sv
// Self-checking bench for triple_pulse_stretcher with a cycle-count reference model.
module tb_triple_pulse_stretcher;

  localparam int HBW  = 2;
  localparam int HOLD = 3;
  localparam int PER  = 1 << HBW;

  logic sysclk = 1'b0;
  logic reset  = 1'b1;
  logic P0 = 1'b0, P1 = 1'b0, P2 = 1'b0;
  logic L0, L1, L2, busy, collide;

  int checks = 0;
  int errors = 0;

  // reference model: cycles since reset, active channel (0 = none), ticks left
  int m_cyc  = 0;
  int m_ch   = 0;
  int m_left = 0;
  int m_col  = 0;
  int l0_hi  = 0;

  triple_pulse_stretcher #(.HB_WIDTH(HBW), .HOLD(HOLD)) dut (
    .sysclk (sysclk),
    .reset  (reset),
    .P0     (P0),
    .P1     (P1),
    .P2     (P2),
    .L0     (L0),
    .L1     (L1),
    .L2     (L2),
    .busy   (busy),
    .collide(collide)
  );

  always #5 sysclk = ~sysclk;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      errors++;
      $display("FAIL %s obs=%0d exp=%0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // one clock edge: drive inputs, advance the model, compare after the edge
  task automatic step(input logic [2:0] p, input logic r);
    int n;
    int first;
    bit tick_now;
    P0 = p[0]; P1 = p[1]; P2 = p[2]; reset = r;
    @(posedge sysclk);
    if (r) begin
      m_cyc = 0; m_ch = 0; m_left = 0; m_col = 0;
    end else begin
      // tick is high in the cycle just before every multiple of PER edges
      m_cyc++;
      tick_now = (m_cyc % PER) == 0;
      n = int'(p[0]) + int'(p[1]) + int'(p[2]);
      first = p[0] ? 1 : (p[1] ? 2 : 3);
      m_col = (n >= 2) ? 1 : 0;
      if (n == 1) begin
        m_ch = first;
        m_left = HOLD;
      end else if (tick_now && m_left > 0) begin
        m_left--;
        if (m_left == 0) m_ch = 0;
      end
    end
    @(negedge sysclk);
    chk("L0", int'(L0), (m_ch == 1 && m_left > 0) ? 1 : 0);
    chk("L1", int'(L1), (m_ch == 2 && m_left > 0) ? 1 : 0);
    chk("L2", int'(L2), (m_ch == 3 && m_left > 0) ? 1 : 0);
    chk("busy", int'(busy), (m_left > 0) ? 1 : 0);
    chk("collide", int'(collide), m_col);
    if (L0) l0_hi++;
  endtask

  task automatic idle(input int k);
    for (int i = 0; i < k; i++) step(3'b000, 1'b0);
  endtask

  initial begin
    // basic stretch: P0 at edge 1, L0 high for 11 cycles
    step(3'b000, 1'b1);
    l0_hi = 0;
    step(3'b001, 1'b0);
    idle(13);
    chk("basic_l0_cycles", l0_hi, 11);

    // retrigger: P1 at edges 1 and 6, falls after edge 16
    step(3'b000, 1'b1);
    step(3'b010, 1'b0);
    idle(4);
    step(3'b010, 1'b0);
    idle(9);
    chk("retrig_l1_edge15", int'(L1), 1);
    idle(1);
    chk("retrig_l1_edge16", int'(L1), 0);

    // takeover: P0 at edge 1, P2 at edge 5
    step(3'b000, 1'b1);
    step(3'b001, 1'b0);
    idle(3);
    step(3'b100, 1'b0);
    chk("takeover_l0", int'(L0), 0);
    chk("takeover_l2", int'(L2), 1);
    idle(12);

    // collision idle at edge 2, then while L2 active
    step(3'b000, 1'b1);
    idle(1);
    step(3'b011, 1'b0);
    chk("coll_idle", int'(collide), 1);
    idle(2);
    step(3'b100, 1'b0);
    idle(1);
    step(3'b101, 1'b0);
    chk("coll_busy_l2", int'(L2), 1);
    idle(12);

    // tick/load coincidence: P1 at edge 4, falls after edge 16
    step(3'b000, 1'b1);
    idle(3);
    step(3'b010, 1'b0);
    idle(11);
    chk("coinc_l1_edge15", int'(L1), 1);
    idle(1);
    chk("coinc_l1_edge16", int'(L1), 0);

    // reset mid-hold with P0 in the reset cycle
    step(3'b000, 1'b1);
    step(3'b001, 1'b0);
    idle(4);
    step(3'b001, 1'b1);
    chk("rst_mid_busy", int'(busy), 0);
    idle(10);

    // randomized traffic with sparse pulses, collisions, held inputs and resets
    for (int i = 0; i < 3000; i++) begin
      logic [2:0] p;
      logic r;
      int sel;
      sel = $urandom_range(0, 99);
      if (sel < 80)      p = 3'b000;
      else if (sel < 92) p = 3'b001 << $urandom_range(0, 2);
      else               p = 3'($urandom_range(0, 7));
      r = ($urandom_range(0, 249) == 0);
      step(p, r);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/triple_pulse_stretcher.md
# triple_pulse_stretcher

Output-side counterpart of the three-channel button debouncer. It takes single-cycle event pulses on three channels (for example, debounced button events or FSM strobes) and turns them into human-visible, mutually exclusive level outputs held for a programmable number of heartbeat ticks. It drives LEDs or buzzer enables on the board side of the design and has its own internal heartbeat prescaler.

## Interface
Parameters:
- HB_WIDTH, 21: prescaler width. One heartbeat tick occurs every 2^HB_WIDTH sysclk cycles.
- HOLD, 3: hold length in ticks. Legal range is 1 to 15. The counter is 4 bits wide.

Ports:
- sysclk, input, 1: system clock. Every register updates on its rising edge.
- reset, input, 1: synchronous, active-high reset.
- P0, input, 1: channel 0 event pulse, one cycle wide.
- P1, input, 1: channel 1 event pulse, one cycle wide.
- P2, input, 1: channel 2 event pulse, one cycle wide.
- L0, output, 1: channel 0 stretched level. Registered.
- L1, output, 1: channel 1 stretched level. Registered.
- L2, output, 1: channel 2 stretched level. Registered.
- busy, output, 1: L0|L1|L2.
- collide, output, 1: one-cycle flag. High for one cycle when 2 or more of P0..P2 were high in the same cycle. Registered.

## Operation
- **Prescaler `pre`:** HB_WIDTH bits; increments by 1 every cycle and wraps from all-ones to 0.
- **tick:** combinational, `tick = (pre == all-ones)`.
- **Channel register `act`:** 2 bits, encoded as 0 = idle, 1 = channel 0, 2 = channel 1, 3 = channel 2.
- **Hold counter `cnt`:** 4 bits.
- **Outputs:** `Li = (act == i+1) && (cnt != 0)`, registered. At most one Li is high at any time.
- **Accepted pulse:** exactly one of P0..P2 is high.
  - Load `act` with that channel and load `cnt = HOLD`.
  - This applies whether the block is idle, the same channel is active (retrigger restarts the hold), or a different channel is active (takeover: the old output drops on the same edge the new one rises).
- **Collision:** 2 or more of P0..P2 are high in the same cycle.
  - No load occurs; the current channel continues unchanged.
  - `collide` = 1 for one cycle.
- **Decrement:** when `tick` = 1, no pulse is accepted, and `cnt != 0`, decrement `cnt` by 1. When `cnt` reaches 0, set `act` to 0.
- **Tick and accepted pulse in the same cycle:** the load wins, so `cnt = HOLD`, not HOLD-1.
- **Prescaler independence:** the prescaler is never reset by pulses. Hold duration therefore depends on tick phase.
- **Underflow:** `cnt` never goes below 0. A tick while idle has no effect.

## Timing
- **Reset:** reset high at an edge sets `pre = 0`, `cnt = 0`, `act = 0`, L0..L2 = 0, busy = 0 and collide = 0. This takes priority over everything, including mid-hold, and pulses in the reset cycle are dropped.
- **Latency:** a pulse sampled at edge k makes Li high after edge k (one-cycle latency).
- **Collide timing:** collide is high during the cycle after the colliding inputs.
- **Hold duration:** `(HOLD-1)*2^HB_WIDTH + 1` to `HOLD*2^HB_WIDTH` cycles, measured from the accepting edge to the edge at which Li falls.
- **First tick after reset:** reset released at edge 0 puts `tick` high in the cycle between edges 2^HB_WIDTH-1 and 2^HB_WIDTH.
- **Pulse width:** inputs must be one cycle wide. A held-high input is treated as a retrigger every cycle, so the output stays high.

## Test plan
All scenarios use HB_WIDTH=2 and HOLD=3. Ticks are sampled at edges 4, 8, 12, … after reset is released at edge 0.
- **Basic stretch:** P0 pulse sampled at edge 1 → L0 = 1 after edge 1, `cnt` goes 3→2→1→0 at edges 4, 8 and 12, L0 = 0 after edge 12 (11 cycles high), and busy tracks L0.
- **Retrigger:** P1 at edge 1, then P1 again at edge 6 → L1 stays high with no gap and falls after edge 16.
- **Takeover:** P0 at edge 1, then P2 at edge 5 → after edge 5, L0 = 0 and L2 = 1 in the same cycle. L2 falls after edge 16.
- **Collision:** P0 and P1 together at edge 2 while idle → collide = 1 for one cycle after edge 2 and all Li stay 0. Repeat while L2 is active → L2 is unaffected and falls at its original time.
- **Tick/load coincidence:** P1 at edge 4 (a tick edge) → `cnt` = 3 after edge 4 and L1 falls after edge 16, i.e. no tick is consumed at edge 4.
- **Reset mid-hold:** P0 at edge 1, then reset high at edge 6 → all outputs 0 and `pre` = 0 after edge 6. A P0 pulse in the reset cycle is ignored. The next tick is sampled at edge 10.
